ternary_serial_adder: RTL



---
 rtl/ternary_serial_adder_if.sv | 34 +++
 rtl/ternary_serial_adder.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/ternary_serial_adder_if.sv
// Bus bundle for ternary_serial_adder: request side (start plus operands) and
// result side (status plus sum/carry-out). Trits are 2-bit codes:
// 2'b10 = -1, 2'b00 = 0, 2'b01 = +1, 2'b11 = invalid.
//   start : begin an addition (sampled in IDLE/DONE only)
//   a, b  : operands, trit i at [2i+1:2i], trit 0 least significant
//   cin   : carry-in trit
//   busy  : trits being processed
//   done  : result valid (one cycle)
//   sum   : result trits, same layout as a
//   cout  : carry-out trit
//   err   : an invalid code was seen in the latched operands
interface ternary_serial_adder_if #(
  parameter int unsigned WIDTH = 9
);
  logic                 start;
  logic [2*WIDTH-1:0]   a;
  logic [2*WIDTH-1:0]   b;
  logic [1:0]           cin;
  logic                 busy;
  logic                 done;
  logic [2*WIDTH-1:0]   sum;
  logic [1:0]           cout;
  logic                 err;

  modport master (
    output start, a, b, cin,
    input  busy, done, sum, cout, err
  );

  modport slave (
    input  start, a, b, cin,
    output busy, done, sum, cout, err
  );
endinterface

// File: rtl/ternary_serial_adder.sv
// Bit-serial balanced-ternary adder: one full-adder stage with a registered
// carry, one trit per cycle, least significant trit first.
//   clk : rising-edge clock
//   rst : synchronous active-high reset
//   bus : ternary_serial_adder_if slave (start/a/b/cin in, busy/done/sum/cout/err out)
module ternary_serial_adder #(
  parameter int unsigned WIDTH = 9
) (
  input  logic                 clk,
  input  logic                 rst,
  ternary_serial_adder_if.slave bus
);

  localparam int unsigned VEC_W = 2 * WIDTH;
  localparam int unsigned IDX_W = $clog2(WIDTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t              r_state;
  logic [VEC_W-1:0]    r_a;
  logic [VEC_W-1:0]    r_b;
  logic [VEC_W-1:0]    r_sum;
  logic [1:0]          r_carry;
  logic [1:0]          r_cout;
  logic                r_cin_bad;
  logic [IDX_W-1:0]    r_idx;
  logic                r_busy;
  logic                r_done;
  logic                r_err;

  logic [IDX_W:0]      w_pos;
  logic [1:0]          w_ta;
  logic [1:0]          w_tb;
  logic signed [2:0]   w_s;
  logic signed [2:0]   w_digit;
  logic signed [2:0]   w_carry_nxt;
  logic                w_bad;

  // Code to value; the invalid code reads as 0.
  function automatic logic signed [2:0] trit_val(input logic [1:0] t);
    if (t == 2'b01) return 3'sd1;
    if (t == 2'b10) return -3'sd1;
    return 3'sd0;
  endfunction

  // Value (-1..+1) to code; only valid codes are produced.
  function automatic logic [1:0] trit_enc(input logic signed [2:0] v);
    if (v == 3'sd1)  return 2'b01;
    if (v == -3'sd1) return 2'b10;
    return 2'b00;
  endfunction

  // Bit offset of the current trit.
  assign w_pos = {r_idx, 1'b0};
  assign w_ta  = r_a[w_pos +: 2];
  assign w_tb  = r_b[w_pos +: 2];

  // Balanced-ternary full adder: column sum -3..+3 folded into digit and carry.
  always_comb begin
    w_s         = trit_val(w_ta) + trit_val(w_tb) + trit_val(r_carry);
    w_digit     = w_s;
    w_carry_nxt = 3'sd0;
    if (w_s > 3'sd1) begin
      w_digit     = w_s - 3'sd3;
      w_carry_nxt = 3'sd1;
    end else if (w_s < -3'sd1) begin
      w_digit     = w_s + 3'sd3;
      w_carry_nxt = -3'sd1;
    end
  end

  // An invalid cin was already zeroed at start; it is flagged with the first trit.
  assign w_bad = (w_ta == 2'b11) | (w_tb == 2'b11) | ((r_idx == '0) & r_cin_bad);

  // Control FSM and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_a       <= '0;
      r_b       <= '0;
      r_sum     <= '0;
      r_carry   <= 2'b00;
      r_cout    <= 2'b00;
      r_cin_bad <= 1'b0;
      r_idx     <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (bus.start) begin
            r_state   <= ST_RUN;
            r_a       <= bus.a;
            r_b       <= bus.b;
            r_carry   <= (bus.cin == 2'b11) ? 2'b00 : bus.cin;
            r_cin_bad <= (bus.cin == 2'b11);
            r_idx     <= '0;
            r_sum     <= '0;
            r_cout    <= 2'b00;
            r_err     <= 1'b0;
            r_busy    <= 1'b1;
            r_done    <= 1'b0;
          end else begin
            r_state <= ST_IDLE;
            r_done  <= 1'b0;
          end
        end

        ST_RUN: begin
          r_sum[w_pos +: 2] <= trit_enc(w_digit);
          r_carry           <= trit_enc(w_carry_nxt);
          r_err             <= r_err | w_bad;
          r_idx             <= r_idx + IDX_W'(1);
          if (r_idx == LAST_IDX) begin
            r_state <= ST_DONE;
            r_cout  <= trit_enc(w_carry_nxt);
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end

        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy = r_busy;
  assign bus.done = r_done;
  assign bus.sum  = r_sum;
  assign bus.cout = r_cout;
  assign bus.err  = r_err;

endmodule
